cbus_mem_responder: RTL and testbench

CBUS_MEM_RESPONDER -- requirements
Module: cbus_mem_responder

---
 rtl/cbus_mem_responder.sv | 186 ++++++++++++++++++
 tb/tb_cbus_mem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_mem_responder.sv
// CBUS memory responder: word-addressed backing store serving fixed-length bursts.
// Define CBUS_WRAP_BURST_EN for critical-word-first wrapping within the len-aligned block.
package cbus_pkg;
  typedef enum logic [2:0] {
    MLEN1  = 3'd0,
    MLEN2  = 3'd1,
    MLEN4  = 3'd2,
    MLEN8  = 3'd3,
    MLEN16 = 3'd4
  } cbus_len_e;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_e   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_mem_responder
  import cbus_pkg::*;
#(
  parameter int MEM_WORDS     = 4096,
  parameter int FIRST_LATENCY = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       busy
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_LAST = 4'(FIRST_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_e;

  state_e          state_r, state_s;
  logic [AW-1:0]   word_r;
  logic            is_write_r;
  cbus_len_e       len_r;
  logic [3:0]      beat_cnt_r, beat_cnt_s;
  logic [3:0]      lat_cnt_r, lat_cnt_s;
  logic            latch_s;
  logic            ready_s;
  logic            last_s;
  logic            write_s;
  logic [4:0]      beats_s;
  logic [AW-1:0]   mem_addr_s;
  logic [31:0]     mem [MEM_WORDS];

  function automatic logic [4:0] beat_count(input cbus_len_e len);
    case (len)
      MLEN1:   return 5'd1;
      MLEN2:   return 5'd2;
      MLEN4:   return 5'd4;
      MLEN8:   return 5'd8;
      MLEN16:  return 5'd16;
      default: return 5'd1;
    endcase
  endfunction

  function automatic logic [31:0] apply_strobe(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strobe);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strobe[b]) res[8*b +: 8] = new_word[8*b +: 8];
      else           res[8*b +: 8] = old_word[8*b +: 8];
    end
    return res;
  endfunction

  // Beat address generation: linear, or wrapped inside the len-aligned block.
  always_comb begin
    beats_s = beat_count(len_r);
`ifdef CBUS_WRAP_BURST_EN
    begin
      logic [AW-1:0] mask_s;
      mask_s     = AW'(beats_s - 5'd1);
      mem_addr_s = (word_r & ~mask_s) | ((word_r + AW'(beat_cnt_r)) & mask_s);
    end
`else
    mem_addr_s = word_r + AW'(beat_cnt_r);
`endif
  end

  // Beat status decode from the registered state.
  always_comb begin
    ready_s = (state_r == BURST);
    last_s  = ready_s && ({1'b0, beat_cnt_r} == (beats_s - 5'd1));
    write_s = ready_s && is_write_r;
  end

  // Next-state and counter logic.
  always_comb begin
    state_s    = state_r;
    beat_cnt_s = beat_cnt_r;
    lat_cnt_s  = lat_cnt_r;
    latch_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (creq.valid) begin
          latch_s    = 1'b1;
          beat_cnt_s = 4'd0;
          lat_cnt_s  = 4'd0;
          state_s    = (FIRST_LATENCY > 0) ? WAIT : BURST;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (lat_cnt_r == LAT_LAST) begin
          lat_cnt_s = 4'd0;
          state_s   = BURST;
        end else begin
          lat_cnt_s = lat_cnt_r + 4'd1;
        end
      end
      BURST: begin
        if (last_s) begin
          beat_cnt_s = 4'd0;
          state_s    = IDLE;
        end else begin
          beat_cnt_s = beat_cnt_r + 4'd1;
        end
      end
      default: begin
        state_s    = IDLE;
        beat_cnt_s = 4'd0;
        lat_cnt_s  = 4'd0;
      end
    endcase
  end

  // State, counters and the request fields latched at acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= IDLE;
      beat_cnt_r <= 4'd0;
      lat_cnt_r  <= 4'd0;
      word_r     <= '0;
      is_write_r <= 1'b0;
      len_r      <= MLEN1;
    end else begin
      state_r    <= state_s;
      beat_cnt_r <= beat_cnt_s;
      lat_cnt_r  <= lat_cnt_s;
      if (latch_s) begin
        word_r     <= creq.addr[AW+1:2];
        is_write_r <= creq.is_write;
        len_r      <= creq.len;
      end
    end
  end

  // Store writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem[mem_addr_s] <= apply_strobe(mem[mem_addr_s], creq.data, creq.strobe);
    end
  end

  // Response drive; read data is forced to zero outside read beats.
  always_comb begin
    cresp       = '0;
    cresp.ready = ready_s;
    cresp.last  = last_s;
    if (ready_s && !is_write_r) cresp.data = mem[mem_addr_s];
    else                        cresp.data = 32'd0;
    busy = (state_r != IDLE);
  end
endmodule

// File: tb/tb_cbus_mem_responder.sv
// Randomized self-checking bench for cbus_mem_responder against an array-based store model.
// Two instances: FIRST_LATENCY=2 (main) and FIRST_LATENCY=0 (back-to-back timing).
module tb_cbus_mem_responder;
  import cbus_pkg::*;

  localparam int MW   = 256;
  localparam int FL_A = 2;
  localparam int FL_B = 0;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  cbus_req_t  creq_a, creq_b;
  cbus_resp_t cresp_a, cresp_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [2][MW];
  logic [31:0] wdata [16];
  logic [3:0]  strb  [16];
  logic [31:0] got   [16];

  always #5 clk = ~clk;

  cbus_mem_responder #(.MEM_WORDS(MW), .FIRST_LATENCY(FL_A)) dut_a (
    .clk(clk), .resetn(resetn), .creq(creq_a), .cresp(cresp_a), .busy(busy_a));

  cbus_mem_responder #(.MEM_WORDS(MW), .FIRST_LATENCY(FL_B)) dut_b (
    .clk(clk), .resetn(resetn), .creq(creq_b), .cresp(cresp_b), .busy(busy_b));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Word index of beat k, derived from the addressing rules with plain arithmetic.
  function automatic int model_word(input logic [31:0] addr, input cbus_len_e len, input int k);
    int n;
    int w;
    n = 1 << int'(len);
    w = int'(addr >> 2);
`ifdef CBUS_WRAP_BURST_EN
    w = (w / n) * n + ((w % n) + k) % n;
`else
    w = w + k;
`endif
    return w % MW;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  task automatic set_req(input bit sel, input cbus_req_t r);
    if (sel) creq_b = r;
    else     creq_a = r;
  endtask

  // One burst; abort_at >= 0 pulls reset on that beat.
  task automatic burst(input bit sel, input bit wr, input logic [31:0] addr,
                       input cbus_len_e len, input int abort_at);
    cbus_req_t  r;
    cbus_resp_t rs;
    logic       bz;
    int n, lat, beat, w;
    n    = 1 << int'(len);
    lat  = sel ? FL_B : FL_A;
    r    = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.addr     = addr;
    r.len      = len;
    r.size     = 2'($urandom);
    r.data     = wdata[0];
    r.strobe   = strb[0];
    set_req(sel, r);
    beat = 0;
    for (int cyc = 1; cyc <= lat + n; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      rs = sel ? cresp_b : cresp_a;
      bz = sel ? busy_b : busy_a;
      check_eq("busy", bz, 1'b1);
      if (cyc == 1) begin
        // Request fields change after acceptance; the burst must not notice.
        r.addr     = $urandom;
        r.len      = cbus_len_e'(3'($urandom_range(0, 4)));
        r.is_write = ~wr;
        r.valid    = 1'($urandom_range(0, 1));
      end
      if (cyc <= lat) begin
        check_eq("wait_ready", rs.ready, 1'b0);
        check_eq("wait_data", rs.data, 32'd0);
        set_req(sel, r);
      end else begin
        check_eq("beat_ready", rs.ready, 1'b1);
        check_eq("beat_last", rs.last, beat == n - 1);
        w = model_word(addr, len, beat);
        if (wr) begin
          r.data   = wdata[beat];
          r.strobe = strb[beat];
          model[sel][w] = merge(model[sel][w], wdata[beat], strb[beat]);
        end else begin
          got[beat] = rs.data;
          check_eq("read_data", rs.data, model[sel][w]);
        end
        if (beat == n - 1) r.valid = 1'b0;
        set_req(sel, r);
        if (beat == abort_at) begin
          resetn = 1'b0;
          #1;
          rs = sel ? cresp_b : cresp_a;
          bz = sel ? busy_b : busy_a;
          check_eq("abort_ready", rs.ready, 1'b0);
          check_eq("abort_last", rs.last, 1'b0);
          check_eq("abort_busy", bz, 1'b0);
          r.valid = 1'b0;
          set_req(sel, r);
          #2 resetn = 1'b1;
          return;
        end
        beat++;
      end
    end
    check_eq("beat_total", beat, n);
    @(posedge clk);
    @(negedge clk);
    rs = sel ? cresp_b : cresp_a;
    bz = sel ? busy_b : busy_a;
    check_eq("post_busy", bz, 1'b0);
    check_eq("post_ready", rs.ready, 1'b0);
    check_eq("post_data", rs.data, 32'd0);
  endtask

  initial begin
    cbus_req_t r;
    logic      rdy_exp;
    creq_a = '0;
    creq_b = '0;
    #2;
    check_eq("rst_ready", cresp_a.ready, 1'b0);
    check_eq("rst_last", cresp_a.last, 1'b0);
    check_eq("rst_data", cresp_a.data, 32'd0);
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_busy_b", busy_b, 1'b0);
    creq_a.valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_no_accept", busy_a, 1'b0);
    creq_a = '0;
    resetn = 1'b1;

    // Fill the whole main store with known data.
    for (int b = 0; b < MW / 16; b++) begin
      for (int i = 0; i < 16; i++) begin
        wdata[i] = $urandom;
        strb[i]  = 4'hF;
      end
      burst(1'b0, 1'b1, 32'(b * 64), MLEN16, -1);
    end

    // Single-word read with latency.
    wdata[0] = 32'hA5A5_0001;
    strb[0]  = 4'hF;
    burst(1'b0, 1'b1, 32'h40, MLEN1, -1);
    burst(1'b0, 1'b0, 32'h40, MLEN1, -1);
    check_eq("single_word", got[0], 32'hA5A5_0001);

    // Words 0x20..0x2F = 0..15, words 0x30..0x3F = 0x300 + i.
    for (int i = 0; i < 16; i++) begin
      wdata[i] = 32'(i);
      strb[i]  = 4'hF;
    end
    burst(1'b0, 1'b1, 32'h80, MLEN16, -1);
    for (int i = 0; i < 16; i++) wdata[i] = 32'h300 + 32'(i);
    burst(1'b0, 1'b1, 32'hC0, MLEN16, -1);
    burst(1'b0, 1'b0, 32'h80, MLEN16, -1);
    check_eq("inc16_last_word", got[15], 32'd15);
    burst(1'b0, 1'b0, 32'h94, MLEN16, -1);
    check_eq("crit_first", got[0], 32'd5);
`ifdef CBUS_WRAP_BURST_EN
    check_eq("wrap_point", got[11], 32'd0);
`else
    check_eq("wrap_point", got[11], 32'h300);
`endif

    // Byte-masked write burst.
    wdata[0] = 32'hFFFF_FFFF;
    burst(1'b0, 1'b1, 32'h108, MLEN1, -1);
    wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222;
    wdata[2] = 32'h3333_3333; wdata[3] = 32'h4444_4444;
    strb[0] = 4'hF; strb[1] = 4'hF; strb[2] = 4'h3; strb[3] = 4'hF;
    burst(1'b0, 1'b1, 32'h100, MLEN4, -1);
    burst(1'b0, 1'b0, 32'h100, MLEN4, -1);
    check_eq("strobe_word", got[2], 32'hFFFF_3333);

    // Reset during a burst, then a normal read.
    burst(1'b0, 1'b0, 32'h80, MLEN16, 4);
    burst(1'b0, 1'b0, 32'h40, MLEN1, -1);
    check_eq("after_abort", got[0], 32'hA5A5_0001);

    // Linear run across the end of the store.
    burst(1'b0, 1'b0, 32'h3F8, MLEN16, -1);

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 16; i++) begin
        wdata[i] = $urandom;
        strb[i]  = 4'($urandom);
      end
      burst(1'b0, 1'($urandom_range(0, 1)), $urandom,
            cbus_len_e'(3'($urandom_range(0, 4))), -1);
    end

    // Zero-latency instance: back-to-back MLEN2 reads with valid held.
    for (int i = 0; i < 4; i++) begin
      wdata[i] = 32'hB000_0000 + 32'(i);
      strb[i]  = 4'hF;
    end
    burst(1'b1, 1'b1, 32'h0, MLEN4, -1);
    r = '0;
    r.valid = 1'b1;
    r.addr  = 32'h0;
    r.len   = MLEN2;
    creq_b  = r;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      rdy_exp = (c == 1 || c == 2 || c == 4 || c == 5);
      check_eq("b2b_ready", cresp_b.ready, rdy_exp);
      check_eq("b2b_last", cresp_b.last, c == 2 || c == 5);
      if (rdy_exp) check_eq("b2b_data", cresp_b.data, model[1][(c < 3) ? c - 1 : c - 2]);
      else         check_eq("b2b_idle_data", cresp_b.data, 32'd0);
      if (c == 2) begin
        r.addr = 32'h8;
        creq_b = r;
      end
      if (c == 5) begin
        r.valid = 1'b0;
        creq_b  = r;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
